// File: rtl/mem_request_port.sv
// Request port in front of the memory controller: two one-entry client holding
// registers (fetch, data), round-robin grant, one transaction in flight, watchdog.
module mem_request_port #(
    parameter int   TIMEOUT_CYCLES = 64,
    parameter logic FETCH_VIRTUAL  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fReq,
    input  logic [31:0] fAddr,
    output logic        fRdy,
    output logic        fValid,
    output logic [31:0] fData,
    output logic        fErr,
    input  logic        dReq,
    input  logic        dWrite,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWData,
    input  logic        dVirtual,
    output logic        dRdy,
    output logic        dValid,
    output logic [31:0] dRData,
    output logic        dErr,
    input  logic        execMode,
    output logic [31:0] mcRamAddress,
    output logic [31:0] mcRamIn,
    output logic        mcReadReq,
    output logic        mcWriteReq,
    output logic        mcAddrVirtual,
    output logic        mcExecMode,
    input  logic [31:0] mcRamOut,
    input  logic [1:0]  mcStatus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [1:0] ST_ERR  = 2'd0;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [2:0]    state;
    logic [CW-1:0] cnt;

    logic          f_full;
    logic [31:0]   f_addr_q;
    logic          f_exec_q;

    logic          d_full;
    logic          d_write_q;
    logic [31:0]   d_addr_q;
    logic [31:0]   d_wdata_q;
    logic          d_virt_q;
    logic          d_exec_q;

    logic          last_data;   // 1: data was granted last
    logic          gnt_data;    // client owning the in-flight transaction

    logic          pick_data;
    logic          resp_done;
    logic          resp_err;
    logic          timed_out;
    logic          finish;

    // Holding register stays closed through the completion pulse, reopening a cycle later.
    assign fRdy = !f_full && !fValid;
    assign dRdy = !d_full && !dValid;

    assign pick_data = d_full && (!f_full || !last_data);
    assign resp_done = (mcStatus == ST_DONE);
    assign resp_err  = (mcStatus == ST_ERR);
    assign timed_out = (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign finish    = (state == S_WAIT) && (resp_done || resp_err || timed_out);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            f_full        <= 1'b0;
            f_addr_q      <= '0;
            f_exec_q      <= 1'b0;
            d_full        <= 1'b0;
            d_write_q     <= 1'b0;
            d_addr_q      <= '0;
            d_wdata_q     <= '0;
            d_virt_q      <= 1'b0;
            d_exec_q      <= 1'b0;
            last_data     <= 1'b0;
            gnt_data      <= 1'b0;
            fValid        <= 1'b0;
            fData         <= '0;
            fErr          <= 1'b0;
            dValid        <= 1'b0;
            dRData        <= '0;
            dErr          <= 1'b0;
            mcRamAddress  <= '0;
            mcRamIn       <= '0;
            mcReadReq     <= 1'b0;
            mcWriteReq    <= 1'b0;
            mcAddrVirtual <= 1'b0;
            mcExecMode    <= 1'b0;
        end else begin
            fValid <= 1'b0;
            fErr   <= 1'b0;
            dValid <= 1'b0;
            dErr   <= 1'b0;

            if (fReq && fRdy) begin
                f_full   <= 1'b1;
                f_addr_q <= fAddr;
                f_exec_q <= execMode;
            end
            if (dReq && dRdy) begin
                d_full    <= 1'b1;
                d_write_q <= dWrite;
                d_addr_q  <= dAddr;
                d_wdata_q <= dWData;
                d_virt_q  <= dVirtual;
                d_exec_q  <= execMode;
            end

            case (state)
                S_IDLE: begin
                    if (f_full || d_full) begin
                        gnt_data  <= pick_data;
                        last_data <= pick_data;
                        state     <= S_ISSUE;
                        if (pick_data) begin
                            mcRamAddress  <= d_addr_q;
                            mcRamIn       <= d_write_q ? d_wdata_q : 32'd0;
                            mcAddrVirtual <= d_virt_q;
                            mcExecMode    <= d_exec_q;
                            mcWriteReq    <= d_write_q;
                            mcReadReq     <= !d_write_q;
                        end else begin
                            mcRamAddress  <= f_addr_q;
                            mcRamIn       <= 32'd0;
                            mcAddrVirtual <= FETCH_VIRTUAL;
                            mcExecMode    <= f_exec_q;
                            mcWriteReq    <= 1'b0;
                            mcReadReq     <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    mcReadReq  <= 1'b0;
                    mcWriteReq <= 1'b0;
                    cnt        <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                    // A real status wins over the watchdog in the same cycle.
                    if (finish) begin
                        state <= (resp_done || resp_err) ? S_GAP : S_DRAIN;
                        if (gnt_data) begin
                            dValid <= 1'b1;
                            dErr   <= !resp_done;
                            d_full <= 1'b0;
                            if (resp_done && !d_write_q) dRData <= mcRamOut;
                        end else begin
                            fValid <= 1'b1;
                            fErr   <= !resp_done;
                            f_full <= 1'b0;
                            if (resp_done) fData <= mcRamOut;
                        end
                    end
                end
                S_GAP: begin
                    state <= S_IDLE;
                end
                S_DRAIN: begin
                    // The abandoned transaction must retire before the controller is reused.
                    if (resp_done || resp_err) state <= S_GAP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
